// File: rtl/core_rrv_exe_div_if.sv
// core_rrv_exe_div_if
//   Q102H/Q103H handshake and data bundle between the core pipeline and the
//   iterative RV32M divider.
//   master : core side (drives request, operands, flush, downstream ready)
//   slave  : divider side (drives stall/ready and both result views)
interface core_rrv_exe_div_if;
    logic        div_req_q102h;
    logic [1:0]  div_op_q102h;
    logic [31:0] reg_rd_data1_q102h;
    logic [31:0] reg_rd_data2_q102h;
    logic        ready_q103h;
    logic        flush_q102h;
    logic        div_ready_q102h;
    logic [31:0] div_result_q102h;
    logic [31:0] div_result_q103h;

    modport master (
        output div_req_q102h, div_op_q102h, reg_rd_data1_q102h,
               reg_rd_data2_q102h, ready_q103h, flush_q102h,
        input  div_ready_q102h, div_result_q102h, div_result_q103h
    );

    modport slave (
        input  div_req_q102h, div_op_q102h, reg_rd_data1_q102h,
               reg_rd_data2_q102h, ready_q103h, flush_q102h,
        output div_ready_q102h, div_result_q102h, div_result_q103h
    );
endinterface

// File: rtl/core_rrv_exe_div.sv
// core_rrv_exe_div
//   Iterative 32-bit restoring divider for DIV/DIVU/REM/REMU in Q102H.
//   Normal operations stall Q102H for 33 cycles; divide-by-zero and signed
//   overflow resolve combinationally with no stall. The selected result is
//   registered into Q103H.
// Ports:
//   clk  : core clock, rising edge
//   rst  : asynchronous active-high reset
//   dif  : slave side of core_rrv_exe_div_if
//          div_op_q102h: 00 DIV, 01 DIVU, 10 REM, 11 REMU
module core_rrv_exe_div (
    input  logic               clk,
    input  logic               rst,
    core_rrv_exe_div_if.slave  dif
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] dsr;
    logic [4:0]  cnt;
    logic        negq;
    logic        negr;
    logic [1:0]  op;
    logic [31:0] res_q103;

    logic        signed_op;
    logic        div0;
    logic        ovf;
    logic        special;
    logic [31:0] abs1;
    logic [31:0] abs2;
    logic [31:0] spec_res;
    logic [31:0] rem_sh;
    logic [31:0] quo_sh;
    logic [32:0] diff;
    logic        fits;
    logic [31:0] done_res;
    logic [31:0] result;
    logic        ready;
    logic        wr_en;

    always_comb begin
        signed_op = ~dif.div_op_q102h[0];
        div0      = (dif.reg_rd_data2_q102h == '0);
        ovf       = signed_op && (dif.reg_rd_data1_q102h == 32'h8000_0000)
                              && (dif.reg_rd_data2_q102h == '1);
        special   = div0 | ovf;

        abs1 = (signed_op && dif.reg_rd_data1_q102h[31]) ?
               (32'd0 - dif.reg_rd_data1_q102h) : dif.reg_rd_data1_q102h;
        abs2 = (signed_op && dif.reg_rd_data2_q102h[31]) ?
               (32'd0 - dif.reg_rd_data2_q102h) : dif.reg_rd_data2_q102h;

        if (div0)
            spec_res = dif.div_op_q102h[1] ? dif.reg_rd_data1_q102h : '1;
        else
            spec_res = dif.div_op_q102h[1] ? '0 : 32'h8000_0000;
    end

    // The shifted partial remainder is really 33 bits wide; its dropped MSB
    // (rem[31]) guarantees the subtraction fits when the divisor is >= 2^31.
    always_comb begin
        rem_sh = {rem[30:0], quo[31]};
        quo_sh = {quo[30:0], 1'b0};
        diff   = {1'b0, rem_sh} - {1'b0, dsr};
        fits   = rem[31] | ~diff[32];
    end

    always_comb begin
        if (op[1])
            done_res = negr ? (32'd0 - rem) : rem;
        else
            done_res = negq ? (32'd0 - quo) : quo;
    end

    always_comb begin
        result = '0;
        if (state == DONE)
            result = done_res;
        else if (state == IDLE && dif.div_req_q102h && special)
            result = spec_res;
    end

    always_comb begin
        ready = 1'b1;
        if (!dif.flush_q102h) begin
            case (state)
                IDLE:    ready = ~(dif.div_req_q102h & ~special);
                CALC:    ready = 1'b0;
                default: ready = 1'b1;
            endcase
        end
    end

    assign wr_en = dif.div_req_q102h & ready & dif.ready_q103h & ~dif.flush_q102h;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            quo   <= '0;
            rem   <= '0;
            dsr   <= '0;
            cnt   <= '0;
            negq  <= 1'b0;
            negr  <= 1'b0;
            op    <= '0;
        end else if (dif.flush_q102h) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (dif.div_req_q102h && !special) begin
                        quo   <= abs1;
                        dsr   <= abs2;
                        rem   <= '0;
                        cnt   <= 5'd31;
                        op    <= dif.div_op_q102h;
                        negq  <= signed_op & (dif.reg_rd_data1_q102h[31] ^
                                              dif.reg_rd_data2_q102h[31]);
                        negr  <= signed_op & dif.reg_rd_data1_q102h[31];
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (fits) begin
                        rem <= diff[31:0];
                        quo <= quo_sh | 32'd1;
                    end else begin
                        rem <= rem_sh;
                        quo <= quo_sh;
                    end
                    cnt <= cnt - 5'd1;
                    if (cnt == '0)
                        state <= DONE;
                end
                DONE: begin
                    if (dif.ready_q103h)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            res_q103 <= '0;
        else if (wr_en)
            res_q103 <= result;
    end

    assign dif.div_ready_q102h  = ready;
    assign dif.div_result_q102h = result;
    assign dif.div_result_q103h = res_q103;

endmodule

// File: tb/tb_core_rrv_exe_div.sv
// tb_core_rrv_exe_div
//   Directed bench for core_rrv_exe_div with hand-computed expected values.
module tb_core_rrv_exe_div;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    core_rrv_exe_div_if dif ();

    core_rrv_exe_div dut (
        .clk (clk),
        .rst (rst),
        .dif (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        dif.div_req_q102h      = 1'b1;
        dif.div_op_q102h       = op;
        dif.reg_rd_data1_q102h = a;
        dif.reg_rd_data2_q102h = b;
        #1;
    endtask

    // Normal divide: count stall cycles, check the DONE view, then the Q103H register.
    task automatic run_div(input string tag, input logic [1:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
        int stalls;
        issue(op, a, b);
        stalls = 0;
        while (dif.div_ready_q102h == 1'b0 && stalls < 100) begin
            stalls++;
            tick();
        end
        chk({tag, "_stalls"}, 32'(stalls), 32'd33);
        chk({tag, "_q102h"}, dif.div_result_q102h, exp);
        tick();
        dif.div_req_q102h = 1'b0;
        #1;
        chk({tag, "_q103h"}, dif.div_result_q103h, exp);
    endtask

    // Special case: no stall, combinational result, registered next edge.
    task automatic run_spec(input string tag, input logic [1:0] op,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp);
        issue(op, a, b);
        chk({tag, "_ready"}, {31'd0, dif.div_ready_q102h}, 32'd1);
        chk({tag, "_q102h"}, dif.div_result_q102h, exp);
        tick();
        dif.div_req_q102h = 1'b0;
        #1;
        chk({tag, "_q103h"}, dif.div_result_q103h, exp);
        chk({tag, "_idle"}, {31'd0, dif.div_ready_q102h}, 32'd1);
    endtask

    initial begin
        logic [31:0] held;
        vectors     = 0;
        miscompares = 0;
        rst                    = 1'b1;
        dif.div_req_q102h      = 1'b0;
        dif.div_op_q102h       = '0;
        dif.reg_rd_data1_q102h = '0;
        dif.reg_rd_data2_q102h = '0;
        dif.ready_q103h        = 1'b1;
        dif.flush_q102h        = 1'b0;

        tick();
        chk("rst_ready", {31'd0, dif.div_ready_q102h}, 32'd1);
        chk("rst_q102h", dif.div_result_q102h, 32'd0);
        chk("rst_q103h", dif.div_result_q103h, 32'd0);
        rst = 1'b0;
        tick();
        chk("post_rst_ready", {31'd0, dif.div_ready_q102h}, 32'd1);

        run_div("divu_100_7", OP_DIVU, 32'd100, 32'd7, 32'd14);
        tick();
        run_div("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd2);
        tick();
        run_div("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        tick();
        run_div("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        tick();
        run_div("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd1);
        tick();
        run_div("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1);
        tick();
        run_div("remu_big", OP_REMU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE);
        tick();

        run_spec("divu_5_0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run_spec("div_5_0", OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run_spec("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_spec("rem_ovf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        run_spec("remu_5_0", OP_REMU, 32'd5, 32'd0, 32'd5);

        // Flush in the middle of CALC.
        issue(OP_DIVU, 32'd1000, 32'd7);
        chk("fl_accept_stall", {31'd0, dif.div_ready_q102h}, 32'd0);
        repeat (10) tick();
        chk("fl_calc_stall", {31'd0, dif.div_ready_q102h}, 32'd0);
        dif.flush_q102h = 1'b1;
        #1;
        chk("fl_ready_during", {31'd0, dif.div_ready_q102h}, 32'd1);
        tick();
        dif.flush_q102h   = 1'b0;
        dif.div_req_q102h = 1'b0;
        #1;
        chk("fl_idle_ready", {31'd0, dif.div_ready_q102h}, 32'd1);
        chk("fl_q103h_kept", dif.div_result_q103h, 32'd5);
        tick();
        chk("fl_idle_ready2", {31'd0, dif.div_ready_q102h}, 32'd1);
        run_div("divu_9_3", OP_DIVU, 32'd9, 32'd3, 32'd3);
        tick();

        // DONE held by ReadyQ103H low for 4 cycles.
        dif.ready_q103h = 1'b0;
        issue(OP_DIVU, 32'd50, 32'd5);
        begin
            int stalls;
            stalls = 0;
            while (dif.div_ready_q102h == 1'b0 && stalls < 100) begin
                stalls++;
                tick();
            end
            chk("hold_stalls", 32'(stalls), 32'd33);
        end
        held = dif.div_result_q102h;
        chk("hold_done_q102h", held, 32'd10);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_ready", {31'd0, dif.div_ready_q102h}, 32'd1);
            chk("hold_q102h", dif.div_result_q102h, 32'd10);
            chk("hold_q103h", dif.div_result_q103h, 32'd3);
        end
        dif.ready_q103h = 1'b1;
        #1;
        tick();
        dif.div_req_q102h = 1'b0;
        #1;
        chk("hold_q103h_wr", dif.div_result_q103h, 32'd10);
        chk("hold_idle_q102h", dif.div_result_q102h, 32'd0);
        tick();
        chk("hold_q103h_once", dif.div_result_q103h, 32'd10);

        // Asynchronous reset mid-CALC.
        issue(OP_DIVU, 32'd77, 32'd7);
        repeat (5) tick();
        chk("ar_calc_stall", {31'd0, dif.div_ready_q102h}, 32'd0);
        #1;
        rst               = 1'b1;
        dif.div_req_q102h = 1'b0;
        #1;
        chk("ar_ready", {31'd0, dif.div_ready_q102h}, 32'd1);
        chk("ar_q103h", dif.div_result_q103h, 32'd0);
        chk("ar_q102h", dif.div_result_q102h, 32'd0);
        #1;
        rst = 1'b0;
        tick();
        chk("ar_idle_ready", {31'd0, dif.div_ready_q102h}, 32'd1);
        run_div("div_m100_7", OP_DIV, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2);
        tick();
        run_div("rem_m100_7", OP_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
